// File: rtl/cnt_obi_seq.sv
// rtl/cnt_obi_seq.sv - OBI master sequencer that programs, runs and reads back the counter peripheral
// Optional WAIT_TC watchdog: define CNT_OBI_SEQ_TIMEOUT_EN
module cnt_obi_seq #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] CTRL_OFFS   = 32'h0,
  parameter logic [31:0] THR_OFFS    = 32'h4,
  parameter logic [31:0] VAL_OFFS    = 32'h8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] thr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] cnt_val_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        tc_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_THR, S_CLR, S_EN, S_WAIT_TC, S_DIS, S_RD_VAL, S_DONE
  } state_t;

  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + CTRL_OFFS;
  localparam logic [31:0] ADDR_THR  = BASE_ADDR + THR_OFFS;
  localparam logic [31:0] ADDR_VAL  = BASE_ADDR + VAL_OFFS;

  state_t      state_q, state_d;
  logic        rsp_q, rsp_d;      // 0: request phase, 1: waiting for rvalid
  logic [31:0] thr_q, thr_d;
  logic [31:0] cnt_q, cnt_d;

`ifdef CNT_OBI_SEQ_TIMEOUT_EN
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] wdog_q;
  logic        tmo_q, tmo_d;

  // Watchdog counts WAIT_TC cycles; it sits at zero everywhere else so it restarts on entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= (state_q == S_WAIT_TC) ? wdog_q + 32'd1 : '0;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

  // State, phase and data registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rsp_q   <= 1'b0;
      thr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rsp_q   <= rsp_d;
      thr_q   <= thr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer: each bus state issues one request, then waits for its response before advancing
  always_comb begin
    state_d = state_q;
    rsp_d   = rsp_q;
    thr_d   = thr_q;
    cnt_d   = cnt_q;
`ifdef CNT_OBI_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WR_THR;
          rsp_d   = 1'b0;
          thr_d   = thr_i;
`ifdef CNT_OBI_SEQ_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_WR_THR, S_CLR, S_EN, S_DIS, S_RD_VAL: begin
        if (!rsp_q) begin
          if (bus_gnt_i) rsp_d = 1'b1;
        end else if (bus_rvalid_i) begin
          rsp_d = 1'b0;
          case (state_q)
            S_WR_THR: state_d = S_CLR;
            S_CLR:    state_d = S_EN;
            S_EN:     state_d = S_WAIT_TC;
            S_DIS:    state_d = S_RD_VAL;
            default:  begin
              state_d = S_DONE;
              cnt_d   = bus_rdata_i;
            end
          endcase
        end
      end
      S_WAIT_TC: begin
        if (tc_i) state_d = S_DIS;
`ifdef CNT_OBI_SEQ_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          state_d = S_DIS;
          tmo_d   = 1'b1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus drive is decoded from state so a reset drops the request immediately
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    if (!rsp_q) begin
      case (state_q)
        S_WR_THR: begin bus_req_o = 1'b1; bus_we_o = 1'b1; bus_addr_o = ADDR_THR;  bus_wdata_o = thr_q;  end
        S_CLR:    begin bus_req_o = 1'b1; bus_we_o = 1'b1; bus_addr_o = ADDR_CTRL; bus_wdata_o = 32'h2;  end
        S_EN:     begin bus_req_o = 1'b1; bus_we_o = 1'b1; bus_addr_o = ADDR_CTRL; bus_wdata_o = 32'h1;  end
        S_DIS:    begin bus_req_o = 1'b1; bus_we_o = 1'b1; bus_addr_o = ADDR_CTRL; bus_wdata_o = 32'h0;  end
        S_RD_VAL: begin bus_req_o = 1'b1; bus_addr_o = ADDR_VAL; end
        default:  ;
      endcase
    end
  end

  assign bus_be_o  = 4'hF;
  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o    = (state_q == S_DONE);
  assign cnt_val_o = cnt_q;

endmodule

// File: tb/tb_cnt_obi_seq.sv
// tb/tb_cnt_obi_seq.sv - scoreboard bench for cnt_obi_seq with a randomized OBI slave model
module tb_cnt_obi_seq;

  localparam logic [31:0] BASE   = 32'hFFFF_FFF8;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_THR  = BASE + 32'h4;
  localparam logic [31:0] A_VAL  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] thr_i;
  logic        busy_o, done_o, timeout_o;
  logic [31:0] cnt_val_o;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        tc_i;

  cnt_obi_seq #(
    .BASE_ADDR(BASE), .CTRL_OFFS(32'h0), .THR_OFFS(32'h4), .VAL_OFFS(32'h8), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .thr_i(thr_i),
    .busy_o(busy_o), .done_o(done_o), .cnt_val_o(cnt_val_o), .timeout_o(timeout_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .tc_i(tc_i)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { logic [31:0] val; logic tmo; } done_t;
  txn_t  exp_q[$];
  done_t done_q[$];

  int checks = 0, errors = 0;
  int done_cnt = 0, done_cyc = 0, dis_cyc = 0, tc_rise_cyc = 0;

  // slave configuration, written by the test sequence
  int          gnt_min = 0, gnt_max = 0, rsp_max = 0, tc_mode = 0, tc_delay = 0;
  bit          spur = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one accepted start produces these five transactions and one done record
  task automatic push_model(input logic [31:0] thr, input logic [31:0] rdv, input logic tmo);
    exp_q.push_back('{1'b1, A_THR,  thr});
    exp_q.push_back('{1'b1, A_CTRL, 32'h2});
    exp_q.push_back('{1'b1, A_CTRL, 32'h1});
    exp_q.push_back('{1'b1, A_CTRL, 32'h0});
    exp_q.push_back('{1'b0, A_VAL,  32'h0});
    done_q.push_back('{rdv, tmo});
  endtask

  // OBI slave and tc source, driven 1 time unit after each rising edge
  bit          pend = 0, in_req = 0, en_seen = 0, tc_prev = 0;
  int          gwait = 0, rwait = 0, en_rv_cyc = 0;
  logic        s_we;
  logic [31:0] s_addr, s_wd;
  initial begin
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0; tc_i = 0;
    forever begin
      @(posedge clk); #1;
      bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = $urandom;
      if (rst) begin
        pend = 0; in_req = 0;
      end else if (pend) begin
        if (rwait == 0) begin
          bus_rvalid_i = 1; pend = 0;
          if (!s_we) bus_rdata_i = rd_val;
          if (s_we && s_addr == A_CTRL && s_wd == 32'h1) begin en_seen = 1; en_rv_cyc = cyc; end
        end else rwait--;
      end else if (bus_req_o) begin
        if (!in_req) begin in_req = 1; gwait = $urandom_range(gnt_max, gnt_min); end
        if (gwait == 0) begin
          bus_gnt_i = 1; in_req = 0; pend = 1; rwait = $urandom_range(rsp_max, 0);
          s_we = bus_we_o; s_addr = bus_addr_o; s_wd = bus_wdata_o;
          if (bus_we_o && bus_addr_o == A_THR) en_seen = 0;
        end else gwait--;
      end
      if (spur && !pend && !bus_gnt_i && !bus_rvalid_i && $urandom_range(3, 0) == 0) bus_rvalid_i = 1;
      case (tc_mode)
        0:       tc_i = 0;
        1:       tc_i = en_seen && (cyc >= en_rv_cyc + tc_delay);
        default: tc_i = 1;
      endcase
      if (tc_i && !tc_prev) tc_rise_cyc = cyc;
      tc_prev = tc_i;
    end
  end

  // Monitor: compares every granted request and every done pulse against the scoreboard
  logic        p_req = 0, p_gnt = 0, p_we = 0;
  logic [31:0] p_addr = '0, p_wd = '0;
  initial begin
    txn_t  t;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && bus_req_o && p_req && !p_gnt) begin
        chk("req_hold_addr", bus_addr_o, p_addr);
        chk("req_hold_we", {31'h0, bus_we_o}, {31'h0, p_we});
        chk("req_hold_wdata", bus_wdata_o, p_wd);
      end
      if (bus_req_o) chk("byte_enables", {28'h0, bus_be_o}, 32'hF);
      if (bus_req_o && bus_gnt_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_txn: got addr %h we %0d, expected no transaction", bus_addr_o, bus_we_o);
        end else begin
          t = exp_q.pop_front();
          chk("txn_we", {31'h0, bus_we_o}, {31'h0, t.we});
          chk("txn_addr", bus_addr_o, t.addr);
          if (t.we) chk("txn_wdata", bus_wdata_o, t.wdata);
        end
        if (bus_we_o && bus_addr_o == A_CTRL && bus_wdata_o == 32'h0) dis_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++; done_cyc = cyc;
        chk("busy_in_done", {31'h0, busy_o}, 32'h0);
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_o, expected none");
        end else begin
          d = done_q.pop_front();
          chk("cnt_val", cnt_val_o, d.val);
          chk("timeout_flag", {31'h0, timeout_o}, {31'h0, d.tmo});
        end
      end
      p_req = bus_req_o; p_gnt = bus_gnt_i; p_we = bus_we_o; p_addr = bus_addr_o; p_wd = bus_wdata_o;
    end
  end

  task automatic start_seq(input logic [31:0] thr, input logic [31:0] rdv, input logic tmo, output int s);
    push_model(thr, rdv, tmo);
    rd_val = rdv;
    @(posedge clk); #1;
    chk("idle_before_start", {31'h0, busy_o}, 32'h0);
    start_i = 1; thr_i = thr; s = cyc;
    @(posedge clk); #1;
    start_i = 0; thr_i = ~thr;
    chk("busy_after_start", {31'h0, busy_o}, 32'h1);
  endtask

  task automatic finish_seq(input bit noise);
    int d0;
    bit seen;
    d0 = done_cnt; seen = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (done_o) begin seen = 1; break; end
      if (noise) begin start_i = 1'($urandom); thr_i = $urandom; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_wait: got no done_o, expected one within 3000 cycles");
    end
    start_i = noise; thr_i = $urandom;
    @(posedge clk); #1;
    start_i = 0;
    repeat (8) @(posedge clk);
    #1;
    chk("done_once", done_cnt, d0 + 1);
    chk("idle_after", {31'h0, busy_o}, 32'h0);
    chk("txn_left", exp_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    exp_q.delete(); done_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish before 50000 cycles");
    $fatal(1, "hang");
  end

  initial begin
    int  s;
    bit  found;
    logic [31:0] r;
    rst = 1; start_i = 0; thr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_cnt_val", cnt_val_o, 32'h0);
    chk("rst_timeout", {31'h0, timeout_o}, 32'h0);
    chk("rst_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_we", {31'h0, bus_we_o}, 32'h0);
    chk("rst_be", {28'h0, bus_be_o}, 32'hF);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    rst = 0;

    // directed zero-wait run, tc 10 cycles after EN response
    tc_mode = 1; tc_delay = 10;
    start_seq(32'h5, 32'h5, 1'b0, s);
    finish_seq(0);
    chk("tc_to_done", done_cyc - tc_rise_cyc, 5);

    // three-cycle grant delay on every request
    gnt_min = 3; gnt_max = 3; tc_delay = 4;
    start_seq($urandom, $urandom, 1'b0, s);
    finish_seq(0);

    // start pulses while busy and in the done cycle are dropped
    gnt_min = 0; gnt_max = 2; rsp_max = 1;
    start_seq($urandom, $urandom, 1'b0, s);
    finish_seq(1);

    // tc already high before start
    gnt_min = 0; gnt_max = 0; rsp_max = 0; tc_mode = 2;
    repeat (3) @(posedge clk);
    start_seq($urandom, $urandom, 1'b0, s);
    finish_seq(0);
    chk("start_to_dis", dis_cyc - s, 8);
    chk("start_to_done", done_cyc - s, 12);

    // reset during the EN request phase
    gnt_min = 4; gnt_max = 4; tc_mode = 0;
    start_seq($urandom, $urandom, 1'b0, s);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_req_o && bus_we_o && bus_addr_o == A_CTRL && bus_wdata_o == 32'h1) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("en_req_seen", {31'h0, found}, 32'h1);
    #2 rst = 1;
    #1;
    chk("rst_mid_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy_o}, 32'h0);
    exp_q.delete(); done_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_cnt_val", cnt_val_o, 32'h0);
    rst = 0;
    gnt_min = 0; gnt_max = 0; tc_mode = 1; tc_delay = 2;
    start_seq($urandom, $urandom, 1'b0, s);
    finish_seq(0);

`ifdef CNT_OBI_SEQ_TIMEOUT_EN
    // watchdog expiry with tc never raised, then a normal run clears the flag
    tc_mode = 0;
    start_seq($urandom, $urandom, 1'b1, s);
    finish_seq(0);
    chk("tmo_start_to_dis", dis_cyc - s, 23);
    chk("tmo_start_to_done", done_cyc - s, 27);
    chk("tmo_held", {31'h0, timeout_o}, 32'h1);
    tc_mode = 2;
    start_seq($urandom, $urandom, 1'b0, s);
    finish_seq(0);
`else
    // without the watchdog WAIT_TC waits indefinitely
    tc_mode = 0;
    start_seq($urandom, $urandom, 1'b0, s);
    repeat (100) @(posedge clk);
    #1;
    chk("no_dis_pending", exp_q.size(), 2);
    chk("still_busy", {31'h0, busy_o}, 32'h1);
    tc_mode = 2;
    finish_seq(0);
`endif

    // randomized runs: random latencies, spurious rvalid, start noise, thr=0 boundary
    gnt_min = 0; gnt_max = 3; rsp_max = 2; spur = 1;
    for (int k = 0; k < 12; k++) begin
      tc_mode  = ($urandom_range(3, 0) == 0) ? 2 : 1;
      tc_delay = $urandom_range(14, 0);
      r = (k == 0) ? 32'h0 : $urandom;
      start_seq(r, $urandom, 1'b0, s);
      finish_seq(1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_obi_seq.md
Name: cnt_obi_seq

Overview:
- OBI master sequencer directly upstream of the OBI-wrapped counter peripheral; drives its bus and consumes its terminal-count interrupt.
- On a start pulse it runs a fixed program-run-readback sequence:
  - write threshold;
  - clear counter, then enable it;
  - wait for terminal count;
  - disable counter and read back the final count.
- Used by hardware test harnesses and accelerators to time intervals without CPU involvement.

Parameters:
- BASE_ADDR, 32'h0000_0000, counter peripheral base address
- CTRL_OFFS, 32'h0, control register offset (bit0 EN, bit1 CLR)
- THR_OFFS, 32'h4, threshold register offset
- VAL_OFFS, 32'h8, count value register offset
- TIMEOUT_CYC, 1024, WAIT_TC watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  start pulse; ignored while busy_o=1
- thr_i  in  32  threshold, sampled when start is accepted
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle pulse at sequence end
- cnt_val_o  out  32  count read back; held until next done_o
- timeout_o  out  1  last run aborted by watchdog; valid with done_o, held
- bus_req_o  out  1  OBI request
- bus_we_o  out  1  OBI write enable
- bus_be_o  out  4  OBI byte enables; always 4'hF
- bus_addr_o  out  32  OBI address
- bus_wdata_o  out  32  OBI write data
- bus_gnt_i  in  1  OBI grant
- bus_rvalid_i  in  1  OBI response valid
- bus_rdata_i  in  32  OBI read data
- tc_i  in  1  terminal-count interrupt from counter (level)

Behaviour:
- One clock, clk_i; reset is asynchronous and active-high (rst_i).
- Reset values: all outputs 0 except bus_be_o=4'hF. State=IDLE, thr reg=0.
- Reset mid-sequence: bus_req_o drops immediately. Any response that arrives later is ignored; it is the bench's duty not to send it.
- States: IDLE, WR_THR, CLR, EN, WAIT_TC, DIS, RD_VAL, DONE.
- Each bus state (WR_THR, CLR, EN, DIS, RD_VAL) has two phases:
  - REQ phase: bus_req_o=1 and addr/we/wdata held stable until bus_gnt_i=1.
  - RSP phase: bus_req_o=0; wait for bus_rvalid_i, then advance.
- Only one outstanding transaction. rvalid outside a RSP phase is ignored. rvalid is never taken in the same cycle as gnt.
- Transactions:
  - WR_THR: write THR_OFFS <= thr reg.
  - CLR: write CTRL_OFFS <= 32'h2.
  - EN: write CTRL_OFFS <= 32'h1.
  - DIS: write CTRL_OFFS <= 32'h0.
  - RD_VAL: read VAL_OFFS; capture bus_rdata_i into cnt_val_o on rvalid.
- Addresses are BASE_ADDR+offset, modulo 2^32.
- IDLE: start_i=1 samples thr_i, sets busy_o next cycle, goes to WR_THR.
- WAIT_TC:
  - Advance to DIS on the first cycle tc_i=1.
  - tc_i is ignored in every other state, so a stale tc level before EN completes has no effect.
  - tc_i already high on entry advances in 1 cycle.
- DONE: done_o=1 for one cycle, busy_o=0 the same cycle, return to IDLE.
- start_i asserted in DONE or any busy state: dropped, not queued.
- Latency with a zero-wait slave (gnt in the REQ cycle, rvalid the next cycle):
  - 2 cycles per transaction.
  - start to WAIT_TC entry: 1 + 3*2 = 7 cycles.
  - tc_i to done_o: 1 + 2*2 = 5 cycles.
- thr_i=0 is passed through unchanged; the counter's behaviour decides tc.

Optional Feature:
- Macro CNT_OBI_SEQ_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog clears on WAIT_TC entry and increments each WAIT_TC cycle.
  - When it reaches TIMEOUT_CYC with tc_i=0, go to DIS and set timeout_o=1.
  - Sequence then completes normally: disable, read back, done_o.
  - tc_i=1 in the expiry cycle takes priority (no timeout).
  - timeout_o clears on the next accepted start.
- Undefined: no watchdog logic; timeout_o tied 0; WAIT_TC waits indefinitely.

Test Plan:
- Zero-wait slave, thr_i=5, start pulse, tc_i raised 10 cycles after EN rvalid, slave returns 0x5 on VAL read. Required response:
  - bus writes THR=0x5, CTRL=0x2, CTRL=0x1, CTRL=0x0, then read of 0x8, in that order;
  - done_o 5 cycles after tc_i;
  - cnt_val_o=0x5.
- Slave delays gnt by 3 cycles on each request: addr/wdata/we stay stable while bus_req_o=1; sequence completes with identical transaction order.
- start_i pulsed again while busy_o=1 and in the done_o cycle: no extra bus transactions; exactly one done_o.
- tc_i held high from before start: tc ignored until WAIT_TC; DIS issued 1 cycle after WAIT_TC entry.
- rst_i asserted during the EN REQ phase: bus_req_o=0, busy_o=0 in the same cycle; next start runs a full clean sequence.
- With CNT_OBI_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, tc_i never set: DIS issued after 16 WAIT_TC cycles, done_o with timeout_o=1. Without the macro: no DIS after 100 cycles.
